// File: rtl/guard_receiver.sv
// -----------------------------------------------------------------------------
// guard_receiver
//   Guard side of the bit-serial passcode link. Answers the sender's rq/ak
//   handshake, shifts in a WIDTH-bit word MSB first and compares it with the
//   stored secret. Reports grant or failure and enforces a timed lockout after
//   MAX_FAILS consecutive failures. A frame that stalls mid-way for TIMEOUT
//   cycles is aborted and counted as a failure.
//
// Ports
//   clk           in   clock, all state on the rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   arms the guard; only gates the start of a frame
//   secret        in   stored passcode, sampled in CHECK
//   rq            in   sender request, din valid while high
//   din           in   serial data, MSB first
//   rd            out  ready for a new frame (IDLE and armed)
//   ak            out  per-bit acknowledge, high ACK_CYCLES cycles per bit
//   rx_word       out  last fully received word
//   granted       out  sticky grant, cleared when en drops in GRANTED
//   match_pulse   out  1-cycle pulse on a correct passcode
//   fail_pulse    out  1-cycle pulse on a wrong passcode or a timeout
//   timeout_pulse out  1-cycle pulse on a mid-frame abort
//   locked        out  high for the whole lockout period
//   fail_count    out  consecutive failures, saturating at MAX_FAILS
// -----------------------------------------------------------------------------
module guard_receiver #(
  parameter int WIDTH       = 16,
  parameter int ACK_CYCLES  = 2,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [WIDTH-1:0]                 secret,
  input  logic                             rq,
  input  logic                             din,
  output logic                             rd,
  output logic                             ak,
  output logic [WIDTH-1:0]                 rx_word,
  output logic                             granted,
  output logic                             match_pulse,
  output logic                             fail_pulse,
  output logic                             timeout_pulse,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int ACW = $clog2(ACK_CYCLES + 1);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [BCW-1:0] BIT_FULL  = BCW'(WIDTH);
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [FCW-1:0] FAIL_MAX  = FCW'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACK      = 3'd1,
    S_WAIT_RQL = 3'd2,
    S_WAIT_RQ  = 3'd3,
    S_CHECK    = 3'd4,
    S_LOCKED   = 3'd5,
    S_GRANTED  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [ACW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [FCW-1:0]   fail_count_q, fail_count_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic             ak_q, ak_d;
  logic             granted_q, granted_d;
  logic             match_q, match_d;
  logic             fail_q, fail_d;
  logic             tmo_pulse_q, tmo_pulse_d;
  logic             locked_q, locked_d;

  // Shared decode used by both combinational processes.
  logic             frame_start;
  logic             word_match;
  logic             tmo_hit;
  logic             fail_event;
  logic [FCW-1:0]   fail_inc;
  state_t           fail_target;

  assign rd          = (state_q == S_IDLE) & en;
  assign frame_start = rd & rq;
  assign word_match  = (sr_q == secret);

  // The idle counter only matters while the state would otherwise be held:
  // a sender edge that moves the FSM on always wins over the abort.
  assign tmo_hit = (((state_q == S_WAIT_RQ)  & ~rq) |
                    ((state_q == S_WAIT_RQL) &  rq)) &
                   (tmo_cnt_q == TMO_LAST);

  assign fail_event = ((state_q == S_CHECK) & ~word_match) | tmo_hit;

  // Saturating increment; lockout normally resets the count before it could
  // ever be asked to pass MAX_FAILS.
  assign fail_inc    = (fail_count_q == FAIL_MAX) ? fail_count_q
                                                  : fail_count_q + FCW'(1);
  assign fail_target = (fail_inc == FAIL_MAX) ? S_LOCKED : S_IDLE;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      ack_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      fail_count_q <= '0;
      rx_word_q    <= '0;
      ak_q         <= 1'b0;
      granted_q    <= 1'b0;
      match_q      <= 1'b0;
      fail_q       <= 1'b0;
      tmo_pulse_q  <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bitcnt_q     <= bitcnt_d;
      ack_cnt_q    <= ack_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      fail_count_q <= fail_count_d;
      rx_word_q    <= rx_word_d;
      ak_q         <= ak_d;
      granted_q    <= granted_d;
      match_q      <= match_d;
      fail_q       <= fail_d;
      tmo_pulse_q  <= tmo_pulse_d;
      locked_q     <= locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_ACK;
      end
      S_ACK: begin
        if (ack_cnt_q == ACK_LAST) state_d = S_WAIT_RQL;
      end
      S_WAIT_RQL: begin
        // A bit is only complete once rq has been seen low, so a long rq can
        // never be sampled twice.
        if (!rq) state_d = (bitcnt_q == BIT_FULL) ? S_CHECK : S_WAIT_RQ;
        else if (tmo_hit) state_d = fail_target;
      end
      S_WAIT_RQ: begin
        if (rq) state_d = S_ACK;
        else if (tmo_hit) state_d = fail_target;
      end
      S_CHECK: begin
        state_d = word_match ? S_GRANTED : fail_target;
      end
      S_LOCKED: begin
        if (lock_cnt_q == LOCK_LAST) state_d = S_IDLE;
      end
      S_GRANTED: begin
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Level outputs follow the state being entered, so each is high for
    // exactly the cycles the FSM spends in the matching state.
    ak_d      = (state_d == S_ACK);
    locked_d  = (state_d == S_LOCKED);
    granted_d = (state_d == S_GRANTED);

    match_d     = (state_q == S_CHECK) & word_match;
    fail_d      = fail_event;
    tmo_pulse_d = tmo_hit;

    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    if ((state_q == S_IDLE) && frame_start) begin
      // First bit of a frame: discard whatever the previous frame left.
      sr_d     = {{(WIDTH-1){1'b0}}, din};
      bitcnt_d = BIT_ONE;
    end else if ((state_q == S_WAIT_RQ) && rq) begin
      sr_d     = {sr_q[WIDTH-2:0], din};
      bitcnt_d = bitcnt_q + BIT_ONE;
    end

    // A timeout leaves rx_word alone; only a completed frame updates it.
    rx_word_d = (state_q == S_CHECK) ? sr_q : rx_word_q;

    fail_count_d = fail_count_q;
    if (fail_event) begin
      fail_count_d = fail_inc;
    end else if (match_d) begin
      fail_count_d = '0;
    end else if ((state_q == S_LOCKED) && (state_d == S_IDLE)) begin
      fail_count_d = '0;
    end

    // Counters restart on every state entry and run while the state holds.
    ack_cnt_d  = ((state_q == S_ACK) && (state_d == S_ACK))
                 ? ack_cnt_q + ACW'(1) : '0;
    lock_cnt_d = ((state_q == S_LOCKED) && (state_d == S_LOCKED))
                 ? lock_cnt_q + LCW'(1) : '0;
    tmo_cnt_d  = ((state_q == state_d) &&
                  ((state_q == S_WAIT_RQ) || (state_q == S_WAIT_RQL)))
                 ? tmo_cnt_q + TCW'(1) : '0;
  end

  assign ak            = ak_q;
  assign rx_word       = rx_word_q;
  assign granted       = granted_q;
  assign match_pulse   = match_q;
  assign fail_pulse    = fail_q;
  assign timeout_pulse = tmo_pulse_q;
  assign locked        = locked_q;
  assign fail_count    = fail_count_q;

endmodule

// File: tb/tb_guard_receiver.sv
// -----------------------------------------------------------------------------
// tb_guard_receiver
//   Drives passcode frames through a sender model, predicts each frame's
//   outcome at the frame level and checks the guard's pulses through a
//   scoreboard queue. A separate monitor also checks ak burst lengths and
//   the lockout duration.
// -----------------------------------------------------------------------------
module tb_guard_receiver;

  localparam int WIDTH       = 16;
  localparam int ACK_CYCLES  = 2;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 64;
  localparam int TIMEOUT     = 255;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] secret;
  logic        rq;
  logic        din;
  logic        rd;
  logic        ak;
  logic [15:0] rx_word;
  logic        granted;
  logic        match_pulse;
  logic        fail_pulse;
  logic        timeout_pulse;
  logic        locked;
  logic [1:0]  fail_count;

  guard_receiver #(
    .WIDTH(WIDTH), .ACK_CYCLES(ACK_CYCLES), .MAX_FAILS(MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .secret(secret), .rq(rq), .din(din),
    .rd(rd), .ak(ak), .rx_word(rx_word), .granted(granted),
    .match_pulse(match_pulse), .fail_pulse(fail_pulse),
    .timeout_pulse(timeout_pulse), .locked(locked), .fail_count(fail_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        match;
    logic        tmo;
    logic [15:0] rx;
    logic [1:0]  fc;
    logic        lk;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int bursts = 0;
  int txn = 0;
  int last_drop_cyc = 0;
  int last_evt_cyc = 0;

  // Frame-level reference model.
  int          m_fail = 0;
  logic [15:0] m_rx = 16'h0;
  logic        m_last_match = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_frame(input logic [15:0] w, input logic tmo);
    exp_t e;
    if (!tmo && (w == secret)) begin
      m_fail = 0;
      m_rx   = w;
      e.match = 1'b1;
    end else begin
      m_fail = (m_fail < MAX_FAILS) ? m_fail + 1 : MAX_FAILS;
      if (!tmo) m_rx = w;
      e.match = 1'b0;
    end
    m_last_match = e.match;
    e.tmo = tmo;
    e.rx  = m_rx;
    e.fc  = 2'(m_fail);
    e.lk  = (m_fail == MAX_FAILS);
    sb.push_back(e);
  endtask

  // Sender model: one rq pulse per bit, held at least `hold` cycles after ak.
  task automatic send_bits(input logic [15:0] w, input int nbits, input int hold, input int en_off);
    for (int b = 0; b < nbits; b++) begin
      int t;
      if (b == en_off) en = 1'b0;
      if (b == en_off + 8) en = 1'b1;
      din = w[15-b];
      rq  = 1'b1;
      t = 0;
      do begin
        @(posedge clk); #1; t++;
      end while (!ak && t < 50);
      if (!ak) begin
        check("ak_rise", 32'(ak), 32'd1);
        rq = 1'b0;
        en = 1'b1;
        return;
      end
      t = 0;
      while ((ak || t < hold) && t < 100) begin
        @(posedge clk); #1; t++;
      end
      rq = 1'b0;
      last_drop_cyc = cyc;
      @(posedge clk); #1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    en = 1'b1;
  endtask

  task automatic wait_sb(input int bound);
    int t = 0;
    while (sb.size() != 0 && t < bound) begin
      @(posedge clk); #1; t++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic clear_grant();
    en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("granted_clear", 32'(granted), 32'd0);
    en = 1'b1;
    #1;
    check("rd_after_grant", 32'(rd), 32'd1);
  endtask

  task automatic wait_unlock();
    int t = 0;
    logic ak_seen = 1'b0;
    check("locked_high", 32'(locked), 32'd1);
    check("rd_in_lock", 32'(rd), 32'd0);
    rq = 1'b1;
    din = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ak) ak_seen = 1'b1;
    end
    rq = 1'b0;
    check("ak_in_lock", 32'(ak_seen), 32'd0);
    while (locked && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("locked_release", 32'(locked), 32'd0);
    m_fail = 0;
    check("fail_count_after_lock", 32'(fail_count), 32'(m_fail));
    check("rd_after_lock", 32'(rd), 32'd1);
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, input int hold, input int en_off);
    int b0;
    logic tmo;
    tmo = (nbits < WIDTH);
    expect_frame(w, tmo);
    b0 = bursts;
    send_bits(w, nbits, hold, en_off);
    wait_sb(tmo ? 300 : 20);
    check("ak_bursts", 32'(bursts - b0), 32'(nbits));
    if (tmo) check("tmo_latency", 32'(last_evt_cyc - last_drop_cyc), 32'(TIMEOUT + 1));
    if (m_last_match) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("granted_hold", 32'(granted), 32'd1);
      check("rd_granted", 32'(rd), 32'd0);
      clear_grant();
    end
    if (m_fail == MAX_FAILS) wait_unlock();
  endtask

  // Monitor: scoreboard pops, ak burst lengths, lockout duration.
  initial begin
    int   ak_len = 0;
    int   lk_len = 0;
    logic ak_prev = 1'b0;
    logic lk_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ak_prev = 1'b0; ak_len = 0;
        lk_prev = 1'b0; lk_len = 0;
        continue;
      end
      if (ak) begin
        if (!ak_prev) bursts++;
        ak_len++;
      end else if (ak_prev) begin
        check("ak_len", 32'(ak_len), 32'(ACK_CYCLES));
        ak_len = 0;
      end
      ak_prev = ak;
      if (locked) begin
        lk_len++;
      end else if (lk_prev) begin
        check("lock_len", 32'(lk_len), 32'(LOCK_CYCLES));
        lk_len = 0;
      end
      lk_prev = locked;
      if (match_pulse || fail_pulse || timeout_pulse) begin
        last_evt_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_pulse", {29'd0, match_pulse, fail_pulse, timeout_pulse}, 32'd0);
        end else begin
          e = sb.pop_front();
          txn++;
          check("pulses", {29'd0, match_pulse, fail_pulse, timeout_pulse},
                {29'd0, e.match, ~e.match, e.tmo});
          check("rx_word", 32'(rx_word), 32'(e.rx));
          check("fail_count", 32'(fail_count), 32'(e.fc));
          check("locked", 32'(locked), 32'(e.lk));
          check("granted", 32'(granted), 32'(e.match));
          $display("txn %0d: match=%0b fail=%0b timeout=%0b rx_word=%04h fail_count=%0d locked=%0b",
                   txn, match_pulse, fail_pulse, timeout_pulse, rx_word, fail_count, locked);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int nb;
    int eo;
    rst_n = 1'b0; en = 1'b0; rq = 1'b0; din = 1'b0; secret = 16'h0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_ak", 32'(ak), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_rx_word", 32'(rx_word), 32'd0);
    check("rst_flags", {26'd0, granted, match_pulse, fail_pulse, timeout_pulse, locked, 1'b0}, 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    secret = 16'hBEEF;
    #1;
    check("rd_idle", 32'(rd), 32'd1);

    // Correct passcode.
    frame(16'hBEEF, 16, 1, -1);

    // Three wrong frames -> lockout.
    secret = 16'h1234;
    repeat (3) frame(16'h0000, 16, 1, -1);

    // Two wrong, then right.
    secret = 16'h5A3C;
    frame(16'h0001, 16, 2, -1);
    frame(16'hFFFF, 16, 0, -1);
    frame(16'h5A3C, 16, 1, -1);

    // Stall after bit 5, then a clean frame.
    secret = 16'hC0DE;
    frame(16'hC0DE, 5, 1, -1);
    frame(16'hC0DE, 16, 1, -1);

    // Asynchronous reset mid-frame.
    secret = 16'hA5A5;
    send_bits(16'h1234, 8, 1, -1);
    en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("arst_ak", 32'(ak), 32'd0);
    check("arst_rd", 32'(rd), 32'd0);
    check("arst_rx_word", 32'(rx_word), 32'd0);
    check("arst_fail_count", 32'(fail_count), 32'd0);
    check("arst_flags", {27'd0, granted, match_pulse, fail_pulse, timeout_pulse, locked}, 32'd0);
    m_fail = 0;
    m_rx = 16'h0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;
    frame(16'hA5A5, 16, 1, -1);

    // Long rq per bit with en toggled mid-frame.
    secret = 16'h7E81;
    frame(16'h7E81, 16, 10, 4);

    // Randomised frames.
    for (int i = 0; i < 20; i++) begin
      secret = 16'($urandom);
      w  = ($urandom_range(0, 2) == 0) ? secret : 16'($urandom);
      nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
      eo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
      frame(w, nb, int'($urandom_range(0, 4)), eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
